// File: rtl/picosoc_bus_arbiter.sv
// Two-master arbiter for the PicoRV32 native memory bus (CPU = m0, DMA/debug = m1).
// Latency: one arbitration cycle (s_valid rises the cycle after the first m*_valid), then slave-paced.
// Backpressure: the grant is held until s_ready (or timeout); the losing master simply waits with valid high.
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   m{0,1}_valid/instr/addr/wdata/wstrb   master request side (wstrb = 0 means read)
//   m{0,1}_ready/rdata           completion and read data back to each master (0 for the non-owner)
//   s_valid/instr/addr/wdata/wstrb        request forwarded to the slave decode
//   s_ready, s_rdata             slave completion and read data
//   grant                        one-hot owner (bit0 = m0, bit1 = m1, 00 = idle)
//   timeout_flag, timeout_clr    sticky bus-timeout status and its clear
//
// Optional build macro PICOSOC_ARB_TIMEOUT_EN adds a per-transfer watchdog that
// terminates a stalled transfer after TIMEOUT_CYCLES cycles with rdata = all ones.
// Without it the arbiter waits for s_ready forever and timeout_flag is tied low.

module picosoc_bus_arbiter #(
    parameter bit       PRIO_FIXED     = 1'b0,   // 0 = round-robin, 1 = m0 wins ties
    parameter bit [7:0] TIMEOUT_CYCLES = 8'd255  // legal range 1..255
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic        m1_instr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_flag,
    input  logic        timeout_clr
);

    // The state encoding is the one-hot grant itself, so grant is a plain copy of the register.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t state;
    logic   last_owner;   // 0 = m0 completed last, 1 = m1 completed last
    logic   own_valid;    // valid of the current owner, 0 when idle
    logic   done;         // normal completion this cycle
    logic   tmo;          // forced termination this cycle
    logic   pick_m1;      // arbitration result in IDLE

    assign grant = state;

    always_comb begin
        own_valid = 1'b0;
        case (state)
            OWN0:    own_valid = m0_valid;
            OWN1:    own_valid = m1_valid;
            default: own_valid = 1'b0;
        endcase
    end

    // s_ready is only meaningful while someone owns the bus; in IDLE own_valid is 0.
    assign done = own_valid & s_ready;

    // m1 wins when it is the only requester, or on a tie under round-robin when m0 went last.
    assign pick_m1 = m1_valid & (~m0_valid | (~PRIO_FIXED & ~last_owner));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_owner <= 1'b1;   // makes m0 win the first tie
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid)
                        state <= pick_m1 ? OWN1 : OWN0;
                end
                default: begin
                    if (done || tmo) begin
                        state      <= IDLE;
                        last_owner <= (state == OWN1);
                    end else if (!own_valid) begin
                        // Master withdrew its request: abandon without touching last_owner.
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Request/response steering. The non-owner always sees ready = 0 and rdata = 0.
    always_comb begin
        s_valid  = 1'b0;
        s_instr  = 1'b0;
        s_addr   = 32'h0;
        s_wdata  = 32'h0;
        s_wstrb  = 4'h0;
        m0_ready = 1'b0;
        m0_rdata = 32'h0;
        m1_ready = 1'b0;
        m1_rdata = 32'h0;
        case (state)
            OWN0: begin
                s_valid  = m0_valid & ~tmo;
                s_instr  = m0_instr;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready | tmo;
                m0_rdata = tmo ? 32'hFFFF_FFFF : s_rdata;
            end
            OWN1: begin
                s_valid  = m1_valid & ~tmo;
                s_instr  = m1_instr;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready | tmo;
                m1_rdata = tmo ? 32'hFFFF_FFFF : s_rdata;
            end
            default: ;
        endcase
    end

`ifdef PICOSOC_ARB_TIMEOUT_EN
    logic [7:0] tmo_cnt;
    logic       tmo_flag_q;

    // A ready arriving in the terminal cycle wins, so the timeout needs !s_ready.
    assign tmo          = own_valid & ~s_ready & (tmo_cnt == TIMEOUT_CYCLES);
    assign timeout_flag = tmo_flag_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_cnt    <= 8'd0;
            tmo_flag_q <= 1'b0;
        end else begin
            // Every OWNx is entered from IDLE, so clearing in IDLE restarts the count per transfer.
            if (state == IDLE)
                tmo_cnt <= 8'd0;
            else if (!s_ready)
                tmo_cnt <= tmo_cnt + 8'd1;

            // Set has priority over a simultaneous clear.
            if (tmo)
                tmo_flag_q <= 1'b1;
            else if (timeout_clr)
                tmo_flag_q <= 1'b0;
        end
    end
`else
    logic unused_tmo;

    assign tmo          = 1'b0;
    assign timeout_flag = 1'b0;
    assign unused_tmo   = ^{timeout_clr, TIMEOUT_CYCLES};
`endif

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Bench for picosoc_bus_arbiter: two instances (round-robin and fixed priority) share one stimulus.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).

module tb_picosoc_bus_arbiter;

    localparam logic [7:0] TMO = 8'd8;

    logic        clk;
    logic        resetn;
    logic        m0_valid, m0_instr, m1_valid, m1_instr;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic        timeout_clr;

    // Index 0 = round-robin instance, index 1 = fixed-priority instance.
    logic        m0_ready_o [2];
    logic        m1_ready_o [2];
    logic [31:0] m0_rdata_o [2];
    logic [31:0] m1_rdata_o [2];
    logic        s_valid_o  [2];
    logic        s_instr_o  [2];
    logic [31:0] s_addr_o   [2];
    logic [31:0] s_wdata_o  [2];
    logic [3:0]  s_wstrb_o  [2];
    logic [1:0]  grant_o    [2];
    logic        flag_o     [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        picosoc_bus_arbiter #(
            .PRIO_FIXED     (g == 1),
            .TIMEOUT_CYCLES (TMO)
        ) u_dut (
            .clk          (clk),
            .resetn       (resetn),
            .m0_valid     (m0_valid),
            .m0_instr     (m0_instr),
            .m0_addr      (m0_addr),
            .m0_wdata     (m0_wdata),
            .m0_wstrb     (m0_wstrb),
            .m0_ready     (m0_ready_o[g]),
            .m0_rdata     (m0_rdata_o[g]),
            .m1_valid     (m1_valid),
            .m1_instr     (m1_instr),
            .m1_addr      (m1_addr),
            .m1_wdata     (m1_wdata),
            .m1_wstrb     (m1_wstrb),
            .m1_ready     (m1_ready_o[g]),
            .m1_rdata     (m1_rdata_o[g]),
            .s_valid      (s_valid_o[g]),
            .s_instr      (s_instr_o[g]),
            .s_addr       (s_addr_o[g]),
            .s_wdata      (s_wdata_o[g]),
            .s_wstrb      (s_wstrb_o[g]),
            .s_ready      (s_ready),
            .s_rdata      (s_rdata),
            .grant        (grant_o[g]),
            .timeout_flag (flag_o[g]),
            .timeout_clr  (timeout_clr)
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [1:0]  grant;
        logic        s_valid;
        logic        s_instr;
        logic [31:0] s_addr;
        logic [31:0] s_wdata;
        logic [3:0]  s_wstrb;
        logic        m0_ready;
        logic        m1_ready;
        logic [31:0] m0_rdata;
        logic [31:0] m1_rdata;
        logic        flag;
    } exp_t;

    int own  [2];   // 0 = nobody, 1 = master 0, 2 = master 1
    int last [2];   // index of the master that completed last
    bit flg  [2];
`ifdef PICOSOC_ARB_TIMEOUT_EN
    int cnt  [2];   // stalled cycles in the current transfer

    function automatic logic model_tmo(int k);
        logic vx;
        vx = (own[k] == 1) ? m0_valid : (own[k] == 2) ? m1_valid : 1'b0;
        return vx && !s_ready && (cnt[k] == int'(TMO));
    endfunction
`endif

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            own[k]  = 0;
            last[k] = 1;
            flg[k]  = 1'b0;
`ifdef PICOSOC_ARB_TIMEOUT_EN
            cnt[k]  = 0;
`endif
        end
    endtask

    function automatic exp_t model_out(int k);
        exp_t e;
        logic t;
        e = '0;
`ifdef PICOSOC_ARB_TIMEOUT_EN
        t = model_tmo(k);
`else
        t = 1'b0;
`endif
        if (own[k] == 1) begin
            e.grant    = 2'b01;
            e.s_valid  = m0_valid && !t;
            e.s_instr  = m0_instr;
            e.s_addr   = m0_addr;
            e.s_wdata  = m0_wdata;
            e.s_wstrb  = m0_wstrb;
            e.m0_ready = s_ready || t;
            e.m0_rdata = t ? 32'hFFFF_FFFF : s_rdata;
        end else if (own[k] == 2) begin
            e.grant    = 2'b10;
            e.s_valid  = m1_valid && !t;
            e.s_instr  = m1_instr;
            e.s_addr   = m1_addr;
            e.s_wdata  = m1_wdata;
            e.s_wstrb  = m1_wstrb;
            e.m1_ready = s_ready || t;
            e.m1_rdata = t ? 32'hFFFF_FFFF : s_rdata;
        end
        e.flag = flg[k];
        return e;
    endfunction

    task automatic model_step(int k);
        logic t, vx;
        vx = (own[k] == 1) ? m0_valid : (own[k] == 2) ? m1_valid : 1'b0;
`ifdef PICOSOC_ARB_TIMEOUT_EN
        t = model_tmo(k);
        if (own[k] == 0)   cnt[k] = 0;
        else if (!s_ready) cnt[k] = (cnt[k] + 1) % 256;
        if (t)                flg[k] = 1'b1;
        else if (timeout_clr) flg[k] = 1'b0;
`else
        t = 1'b0;
`endif
        if (own[k] == 0) begin
            if (m0_valid && m1_valid) own[k] = (k == 1 || last[k] == 1) ? 1 : 2;
            else if (m0_valid)        own[k] = 1;
            else if (m1_valid)        own[k] = 2;
        end else if ((vx && s_ready) || t) begin
            last[k] = own[k] - 1;
            own[k]  = 0;
        end else if (!vx) begin
            own[k] = 0;
        end
    endtask

    task automatic cmp_model(int k, exp_t e);
        string p;
        p = $sformatf("rand.d%0d", k);
        chk({p, ".grant"},    32'(grant_o[k]),    32'(e.grant));
        chk({p, ".s_valid"},  32'(s_valid_o[k]),  32'(e.s_valid));
        chk({p, ".s_instr"},  32'(s_instr_o[k]),  32'(e.s_instr));
        chk({p, ".s_addr"},   s_addr_o[k],        e.s_addr);
        chk({p, ".s_wdata"},  s_wdata_o[k],       e.s_wdata);
        chk({p, ".s_wstrb"},  32'(s_wstrb_o[k]),  32'(e.s_wstrb));
        chk({p, ".m0_ready"}, 32'(m0_ready_o[k]), 32'(e.m0_ready));
        chk({p, ".m1_ready"}, 32'(m1_ready_o[k]), 32'(e.m1_ready));
        chk({p, ".m0_rdata"}, m0_rdata_o[k],      e.m0_rdata);
        chk({p, ".m1_rdata"}, m1_rdata_o[k],      e.m1_rdata);
        chk({p, ".flag"},     32'(flag_o[k]),     32'(e.flag));
    endtask

    // ---------------- helpers ----------------
    task automatic clear_inputs();
        m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 1'b0; s_rdata  = '0;   timeout_clr = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        clear_inputs();
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
    endtask

    typedef struct {
        logic       v0, v1;
        logic [1:0] g_rr;
        logic       r0_rr, r1_rr;
        logic [1:0] g_fx;
        logic       r0_fx, r1_fx;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Both masters request continuously, slave always ready; m0 stops from row 6.
        tbl[0] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 2'b10, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1};

        clear_inputs();
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset.d%0d.grant", k),    32'(grant_o[k]),    32'h0);
            chk($sformatf("reset.d%0d.s_valid", k),  32'(s_valid_o[k]),  32'h0);
            chk($sformatf("reset.d%0d.m0_ready", k), 32'(m0_ready_o[k]), 32'h0);
            chk($sformatf("reset.d%0d.m1_ready", k), 32'(m1_ready_o[k]), 32'h0);
            chk($sformatf("reset.d%0d.flag", k),     32'(flag_o[k]),     32'h0);
        end
        @(negedge clk);
        resetn = 1'b1;

        // ---- table: arbitration patterns ----
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            m0_valid = tbl[i].v0;
            m1_valid = tbl[i].v1;
            s_ready  = 1'b1;
            s_rdata  = 32'hA000_0000 + 32'(i);
            #1;
            chk($sformatf("tbl%0d.rr.grant", i),    32'(grant_o[0]),    32'(tbl[i].g_rr));
            chk($sformatf("tbl%0d.rr.m0_ready", i), 32'(m0_ready_o[0]), 32'(tbl[i].r0_rr));
            chk($sformatf("tbl%0d.rr.m1_ready", i), 32'(m1_ready_o[0]), 32'(tbl[i].r1_rr));
            chk($sformatf("tbl%0d.rr.m0_rdata", i), m0_rdata_o[0], tbl[i].r0_rr ? s_rdata : 32'h0);
            chk($sformatf("tbl%0d.fx.grant", i),    32'(grant_o[1]),    32'(tbl[i].g_fx));
            chk($sformatf("tbl%0d.fx.m0_ready", i), 32'(m0_ready_o[1]), 32'(tbl[i].r0_fx));
            chk($sformatf("tbl%0d.fx.m1_ready", i), 32'(m1_ready_o[1]), 32'(tbl[i].r1_fx));
            chk($sformatf("tbl%0d.fx.m1_rdata", i), m1_rdata_o[1], tbl[i].r1_fx ? s_rdata : 32'h0);
        end
        @(negedge clk);
        clear_inputs();

        // ---- m1 byte write ----
        @(negedge clk);
        m1_valid = 1'b1; m1_addr = 32'h0200_0008; m1_wstrb = 4'b0001; m1_wdata = 32'h41;
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("wr.arb.d%0d.grant", k), 32'(grant_o[k]), 32'h0);
        @(negedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wr.d%0d.grant", k),    32'(grant_o[k]),    32'h2);
            chk($sformatf("wr.d%0d.s_valid", k),  32'(s_valid_o[k]),  32'h1);
            chk($sformatf("wr.d%0d.s_addr", k),   s_addr_o[k],        32'h0200_0008);
            chk($sformatf("wr.d%0d.s_wdata", k),  s_wdata_o[k],       32'h41);
            chk($sformatf("wr.d%0d.s_wstrb", k),  32'(s_wstrb_o[k]),  32'h1);
            chk($sformatf("wr.d%0d.m1_ready0", k), 32'(m1_ready_o[k]), 32'h0);
        end
        @(negedge clk);
        s_ready = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("wr.d%0d.m1_ready", k), 32'(m1_ready_o[k]), 32'h1);
            chk($sformatf("wr.d%0d.m0_ready", k), 32'(m0_ready_o[k]), 32'h0);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("wr.d%0d.idle", k), 32'(grant_o[k]), 32'h0);

        // ---- m0 read, slave ready two cycles after s_valid ----
        @(negedge clk);
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("rd.arb.d%0d.s_valid", k), 32'(s_valid_o[k]), 32'h0);
        @(negedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd.d%0d.s_valid", k), 32'(s_valid_o[k]), 32'h1);
            chk($sformatf("rd.d%0d.grant", k),   32'(grant_o[k]),   32'h1);
            chk($sformatf("rd.d%0d.s_addr", k),  s_addr_o[k],       32'h0000_0010);
        end
        for (int c = 0; c < 1; c++) begin
            @(negedge clk); #1;
            for (int k = 0; k < 2; k++) chk($sformatf("rd.wait.d%0d.m0_ready", k), 32'(m0_ready_o[k]), 32'h0);
        end
        @(negedge clk);
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rd.d%0d.m0_ready", k), 32'(m0_ready_o[k]), 32'h1);
            chk($sformatf("rd.d%0d.m0_rdata", k), m0_rdata_o[k],      32'h1234_5678);
            chk($sformatf("rd.d%0d.m1_ready", k), 32'(m1_ready_o[k]), 32'h0);
            chk($sformatf("rd.d%0d.m1_rdata", k), m1_rdata_o[k],      32'h0);
        end
        @(negedge clk);
        clear_inputs();
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("rd.d%0d.idle", k), 32'(grant_o[k]), 32'h0);

        // ---- reset in the middle of a stalled m0 transfer ----
        // m0 completed last, so without the reset a tie would go to m1 on the round-robin instance.
        @(negedge clk);
        m0_valid = 1'b1;
        @(negedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst.d%0d.grant", k),    32'(grant_o[k]),    32'h1);
            chk($sformatf("rst.d%0d.m0_ready", k), 32'(m0_ready_o[k]), 32'h0);
        end
        #2 resetn = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst.async.d%0d.grant", k),    32'(grant_o[k]),    32'h0);
            chk($sformatf("rst.async.d%0d.s_valid", k),  32'(s_valid_o[k]),  32'h0);
            chk($sformatf("rst.async.d%0d.m0_ready", k), 32'(m0_ready_o[k]), 32'h0);
        end
        @(negedge clk);
        resetn = 1'b1; m1_valid = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("rst.rel.d%0d.grant", k), 32'(grant_o[k]), 32'h0);
        @(negedge clk); #1;
        for (int k = 0; k < 2; k++) chk($sformatf("rst.tie.d%0d.grant", k), 32'(grant_o[k]), 32'h1);
        @(negedge clk);
        clear_inputs();

`ifdef PICOSOC_ARB_TIMEOUT_EN
        // ---- slave never ready: forced termination after TMO stalled cycles ----
        apply_reset();
        @(negedge clk);
        m0_valid = 1'b1;
        for (int c = 0; c <= int'(TMO); c++) begin
            @(negedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                chk($sformatf("tmo%0d.d%0d.grant", c, k), 32'(grant_o[k]), 32'h1);
                if (c < int'(TMO)) begin
                    chk($sformatf("tmo%0d.d%0d.m0_ready", c, k), 32'(m0_ready_o[k]), 32'h0);
                    chk($sformatf("tmo%0d.d%0d.s_valid", c, k),  32'(s_valid_o[k]),  32'h1);
                end else begin
                    chk($sformatf("tmo.d%0d.m0_ready", k), 32'(m0_ready_o[k]), 32'h1);
                    chk($sformatf("tmo.d%0d.m0_rdata", k), m0_rdata_o[k],      32'hFFFF_FFFF);
                    chk($sformatf("tmo.d%0d.s_valid", k),  32'(s_valid_o[k]),  32'h0);
                    chk($sformatf("tmo.d%0d.flag0", k),    32'(flag_o[k]),     32'h0);
                end
            end
        end
        @(negedge clk);
        m0_valid = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("tmo.d%0d.idle", k),   32'(grant_o[k]), 32'h0);
            chk($sformatf("tmo.d%0d.flag1", k),  32'(flag_o[k]),  32'h1);
        end
        @(negedge clk);
        timeout_clr = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("tmo.d%0d.flag_hold", k), 32'(flag_o[k]), 32'h1);
        @(negedge clk);
        timeout_clr = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) chk($sformatf("tmo.d%0d.flag_clr", k), 32'(flag_o[k]), 32'h0);
`endif

        // ---- randomized traffic against the reference model ----
        apply_reset();
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            m0_valid = m0_valid ? ($urandom_range(7) != 0) : ($urandom_range(2) == 0);
            m1_valid = m1_valid ? ($urandom_range(7) != 0) : ($urandom_range(2) == 0);
            m0_instr = 1'($urandom);
            m1_instr = 1'($urandom);
            m0_addr  = $urandom;
            m1_addr  = $urandom;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            m0_wstrb = 4'($urandom);
            m1_wstrb = 4'($urandom);
`ifdef PICOSOC_ARB_TIMEOUT_EN
            s_ready  = ($urandom_range(5) == 0);
`else
            s_ready  = ($urandom_range(2) == 0);
`endif
            s_rdata     = $urandom;
            timeout_clr = ($urandom_range(7) == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                cmp_model(k, model_out(k));
                model_step(k);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
